alu_op_sequencer: RTL

Sequences the shared 4-bit ALU. Operand A arrives from the SPI slave (data plus valid pulse). Operand B is the 2-bit photoresistor decode, zero-extended. The operation is chosen by the four operation buttons (M, S, N, X). The block captures operands, drives the ALU select and inputs, waits a settle time, and registers result and flags for the LEDs and the 4-bit result register. It replaces direct wiring of buttons and SPI to the ALU.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/sync_edge_det.sv | 29 ++
 rtl/alu_op_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXEC,
    WB,
    DONE
  } state_t;

  localparam logic [1:0] ALU_MUL = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  // Bit positions inside the {S,V,C,Z} flag vector.
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_S = 3;

  // Button vector order is [0]=M, [1]=S, [2]=N, [3]=X; input must be one-hot.
  function automatic logic [1:0] btn_to_sel(input logic [3:0] onehot);
    logic [1:0] sel;
    sel = ALU_MUL;
    unique case (onehot)
      4'b0001: sel = ALU_MUL;
      4'b0010: sel = ALU_SUB;
      4'b0100: sel = ALU_AND;
      4'b1000: sel = ALU_XOR;
      default: sel = ALU_MUL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-bit synchronizer chain with a registered-previous rising-edge output.
module sync_edge_det #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  // Shift the asynchronous input through the chain and remember the last synchronized value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= din;
      for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the shared 4-bit ALU: captures operands, holds ALU inputs for a
// settle time and registers result/flags. Optional macro ALU_SEQ_ACCUM_EN adds
// an accum input that takes operand A from the previous result.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] spi_data,
  input  logic       spi_valid,
  input  logic [1:0] sensor_code,
  input  logic [3:0] op_btn,
  input  logic [7:0] alu_result,
  input  logic [3:0] alu_flags,
`ifdef ALU_SEQ_ACCUM_EN
  input  logic       accum,
`endif
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_sel,
  output logic [7:0] result_q,
  output logic [3:0] flags_q,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       operand_pending,
  output logic [7:0] op_count
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] btn_rise;
  logic [1:0] sensor_sync [SYNC_STAGES];
  logic [1:0] sensor_lvl;
  logic [3:0] hold_q;
  logic [1:0] req_sel_q;
  logic [3:0] cnt_q;
  logic       start;
  logic       operand_ok;
`ifdef ALU_SEQ_ACCUM_EN
  logic       accum_q;
`endif

  sync_edge_det #(
    .WIDTH (4),
    .STAGES(SYNC_STAGES)
  ) u_btn_sync (
    .clk  (clk),
    .reset(reset),
    .din  (op_btn),
    .rise (btn_rise)
  );

  // Sensor needs only its synchronized level, so it gets a plain chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sensor_sync[i] <= '0;
    end else begin
      sensor_sync[0] <= sensor_code;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sensor_sync[i] <= sensor_sync[i-1];
    end
  end

  assign sensor_lvl = sensor_sync[SYNC_STAGES-1];

`ifdef ALU_SEQ_ACCUM_EN
  assign operand_ok = accum || operand_pending || spi_valid;
`else
  assign operand_ok = operand_pending || spi_valid;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, request acceptance/rejection and status outputs.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_rise != '0) begin
          if ($onehot(btn_rise) && operand_ok) begin
            state_d = LOAD;
            start   = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
      end
      LOAD:    state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Operand hold, ALU input latches, settle counter and result write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q          <= '0;
      operand_pending <= 1'b0;
      req_sel_q       <= '0;
      cnt_q           <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_sel         <= '0;
      result_q        <= '0;
      flags_q         <= '0;
      op_count        <= '0;
`ifdef ALU_SEQ_ACCUM_EN
      accum_q         <= 1'b0;
`endif
    end else begin
      if (spi_valid) hold_q <= spi_data;

      // A new SPI word in the LOAD cycle stays pending for the next request.
      if (spi_valid) begin
        operand_pending <= 1'b1;
      end else if (state_q == LOAD) begin
`ifdef ALU_SEQ_ACCUM_EN
        if (!accum_q) operand_pending <= 1'b0;
`else
        operand_pending <= 1'b0;
`endif
      end

      if (start) begin
        req_sel_q <= btn_to_sel(btn_rise);
`ifdef ALU_SEQ_ACCUM_EN
        accum_q   <= accum;
`endif
      end

      unique case (state_q)
        LOAD: begin
`ifdef ALU_SEQ_ACCUM_EN
          alu_a <= accum_q ? result_q[3:0] : hold_q;
`else
          alu_a <= hold_q;
`endif
          alu_b   <= {2'b00, sensor_lvl};
          alu_sel <= req_sel_q;
          cnt_q   <= SETTLE_INIT;
        end
        EXEC: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
        end
        WB: begin
          result_q <= alu_result;
          flags_q  <= alu_flags;
          op_count <= op_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
